// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the mem_ctrl command engine: operation codes,
// state encodings and default geometry.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_SUM   = 2'b11
    } op_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    function automatic logic op_writes(input op_t op);
        return (op == OP_WRITE) || (op == OP_FILL);
    endfunction

    function automatic logic op_is_burst(input op_t op);
        return (op == OP_FILL) || (op == OP_SUM);
    endfunction

endpackage

// File: rtl/mem_ctrl_addr_gen.sv
// Address and remaining-word counter for mem_ctrl bursts; the address
// wraps modulo 2^ADDR_W and returns to zero once the last word is issued.
module mem_ctrl_addr_gen #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] start,
    input  logic [ADDR_W-1:0] count_m1,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] remain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            remain <= '0;
        end else if (load) begin
            addr   <= start;
            remain <= count_m1;
        end else if (step) begin
            if (last) begin
                addr   <= '0;
                remain <= '0;
            end else begin
                addr   <= addr + 1'b1;
                remain <= remain - 1'b1;
            end
        end
    end

    assign last = (remain == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Command-driven controller for a 64x16 synchronous-write memory: READ,
// WRITE, FILL and SUM. SUM is built only when MEM_CTRL_SUM_EN is defined.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_write,
    output logic              mem_step,
    input  logic [DATA_W-1:0] mem_dout
);

    state_t            state;
    op_t               op_q;
    op_t               cmd_op_t;
    logic              accept;
    logic              skip;
    logic              ag_load;
    logic              ag_last;
    logic [ADDR_W-1:0] ag_len;
    logic [DATA_W-1:0] rsp_next;
`ifdef MEM_CTRL_SUM_EN
    logic [DATA_W-1:0] acc;
`endif

    assign cmd_op_t = op_t'(cmd_op);
    // cmd_ready is only ever high in IDLE, so it doubles as the state qualifier.
    assign accept   = cmd_valid && cmd_ready;
`ifdef MEM_CTRL_SUM_EN
    assign skip     = 1'b0;
`else
    assign skip     = (cmd_op_t == OP_SUM);
`endif
    assign ag_load  = accept && !skip;
    assign ag_len   = op_is_burst(cmd_op_t) ? cmd_len : '0;

    mem_ctrl_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ag_load),
        .step     (mem_step),
        .start    (cmd_addr),
        .count_m1 (ag_len),
        .addr     (mem_addr),
        .last     (ag_last)
    );

    always_comb begin
        rsp_next = '0;
        case (op_q)
            OP_READ: rsp_next = mem_dout;
`ifdef MEM_CTRL_SUM_EN
            OP_SUM:  rsp_next = acc + mem_dout;
`endif
            default: rsp_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_READ;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            mem_step  <= 1'b0;
            mem_write <= 1'b0;
            mem_din   <= '0;
`ifdef MEM_CTRL_SUM_EN
            acc       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op_t;
                        if (skip) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state     <= ST_ACCESS;
                            mem_step  <= 1'b1;
                            mem_write <= op_writes(cmd_op_t);
                            mem_din   <= cmd_data;
                            rsp_err   <= 1'b0;
                            rsp_data  <= '0;
`ifdef MEM_CTRL_SUM_EN
                            acc       <= '0;
`endif
                        end
                    end
                end
                ST_ACCESS: begin
`ifdef MEM_CTRL_SUM_EN
                    acc <= acc + mem_dout;
`endif
                    if (ag_last) begin
                        state     <= ST_RESP;
                        mem_step  <= 1'b0;
                        mem_write <= 1'b0;
                        mem_din   <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= rsp_next;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
